pulse_freq_meter: RTL

Upstream measurement stage for the 4-digit seven-segment display driver in the PLL demo. It synchronises an external or PLL-derived test signal into the sys_clk domain and emits a one-cycle rising-edge pulse that can drive the display's count input directly. It also counts rising edges over a fixed gate window and converts the count to 4 packed BCD digits for the display. Results update once per gate window, with a valid strobe and an overflow flag.

---
 rtl/freq_meter_pkg.sv | 28 ++
 rtl/pulse_freq_meter_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/pulse_freq_meter.sv | 115 +++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared widths, limits, converter state encoding and the double-dabble
// digit-correction helper for the pulse frequency meter.
package freq_meter_pkg;

  localparam int CNT_W      = 14;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 16;
  localparam logic [CNT_W-1:0] MAX_COUNT = 14'd9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Add 3 to every digit >= 5 so the following left shift carries correctly.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) begin
        res[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pulse_freq_meter_if.sv
// Measurement-side signal bundle: the raw test signal in, the edge pulse
// and the BCD result with its strobe/flags out.
interface pulse_freq_meter_if;
  import freq_meter_pkg::*;

  logic             sig_in;
  logic             edge_pulse;
  logic [BCD_W-1:0] bcd_out;
  logic             meas_valid;
  logic             overflow;
  logic             busy;

  modport master (
    output sig_in,
    input  edge_pulse, bcd_out, meas_valid, overflow, busy
  );

  modport slave (
    input  sig_in,
    output edge_pulse, bcd_out, meas_valid, overflow, busy
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, 14 shifts, then a
// single DONE cycle during which the result is stable on bcd.
module bin2bcd_seq
  import freq_meter_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] LAST_ITER = 4'(CNT_W - 1);

  conv_state_t      state, state_nxt;
  logic [3:0]       iter;
  logic [CNT_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (iter == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  assign bcd_adj = dabble_adjust(bcd_sr);

  // The binary operand shifts its MSB into the corrected BCD accumulator.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      iter   <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            bcd_sr <= '0;
            iter   <= '0;
          end
        end
        SHIFT: begin
          bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[CNT_W-1]};
          bin_sr <= {bin_sr[CNT_W-2:0], 1'b0};
          iter   <= iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bcd = bcd_sr;

endmodule

// File: rtl/pulse_freq_meter.sv
// Synchronises sig_in, emits a one-cycle rising-edge pulse, counts edges per
// gate window and publishes the count as 4 BCD digits once per window.
module pulse_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  pulse_freq_meter_if.slave meter
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_q;

  logic [31:0]            gate_cnt;
  logic                   gate_end;

  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       cnt_final;
  logic                   ovf_pend;
  logic                   ovf_final;
  logic                   ovf_latched;

  logic [BCD_W-1:0]       conv_bcd;
  logic                   conv_busy;
  logic                   conv_done;

  logic [BCD_W-1:0]       bcd_q;
  logic                   overflow_q;
  logic                   valid_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meter.sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  assign gate_end = (gate_cnt == GATE_CYCLES - 32'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) gate_cnt <= '0;
    else            gate_cnt <= gate_end ? '0 : gate_cnt + 32'd1;
  end

  // Count as it stands after this cycle's edge, so a pulse on gate_end
  // lands in the window that is closing.
  always_comb begin
    cnt_final = edge_cnt;
    ovf_final = ovf_pend;
    if (edge_q) begin
      if (edge_cnt == MAX_COUNT) ovf_final = 1'b1;
      else                       cnt_final = edge_cnt + 14'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      edge_cnt    <= '0;
      ovf_pend    <= 1'b0;
      ovf_latched <= 1'b0;
    end else if (gate_end) begin
      edge_cnt    <= '0;
      ovf_pend    <= 1'b0;
      ovf_latched <= ovf_final;
    end else begin
      edge_cnt    <= cnt_final;
      ovf_pend    <= ovf_final;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (gate_end),
    .bin_in    (cnt_final),
    .bcd       (conv_bcd),
    .busy      (conv_busy),
    .done      (conv_done)
  );

  // Published result only moves on DONE; conversion internals never leak out.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= conv_done;
      if (conv_done) begin
        bcd_q      <= conv_bcd;
        overflow_q <= ovf_latched;
      end
    end
  end

  assign meter.edge_pulse = edge_q;
  assign meter.bcd_out    = bcd_q;
  assign meter.meas_valid = valid_q;
  assign meter.overflow   = overflow_q;
  assign meter.busy       = conv_busy;

  gate_end_while_busy: assert property (
    @(posedge sys_clk) disable iff (!sys_rst_n) !(gate_end && conv_busy)
  );

endmodule
